// File: rtl/status_flag_unit.sv
// status_flag_unit: execute-stage ALU and NZCV status register.
// Computes the ALU result and the candidate flags, then holds the
// architectural status word plus a single shadow copy. The shadow copy
// is saved on exception entry and restored on exception return.
module status_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic [3:0]       exe_cmd,
  input  logic             s_bit,
  input  logic             cond_pass,
  input  logic             freeze,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             save_sr,
  input  logic             restore_sr,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       sr,
  output logic [3:0]       sr_fwd,
  output logic [3:0]       shadow_sr
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [3:0]       sr_q, sr_d;
  logic [3:0]       shadow_q, shadow_d;

  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic             carry_in;
  logic             is_arith;
  logic             is_sub;
  logic             is_logic;
  logic [3:0]       flags_calc;
  logic [3:0]       sr_upd;
  logic             update;

  // Decode the command, run the single shared adder and the logic unit.
  // Subtraction is a + ~b + carry_in, so bit WIDTH is directly NOT borrow.
  always_comb begin
    is_arith = 1'b0;
    is_sub   = 1'b0;
    is_logic = 1'b0;
    carry_in = 1'b0;
    result   = '0;
    unique case (exe_cmd)
      CMD_ADD: begin is_arith = 1'b1; carry_in = 1'b0;     end
      CMD_ADC: begin is_arith = 1'b1; carry_in = sr_q[1];  end
      CMD_SUB: begin is_arith = 1'b1; is_sub = 1'b1; carry_in = 1'b1;    end
      CMD_SBC: begin is_arith = 1'b1; is_sub = 1'b1; carry_in = sr_q[1]; end
      CMD_AND: begin is_logic = 1'b1; result = op_a & op_b; end
      CMD_ORR: begin is_logic = 1'b1; result = op_a | op_b; end
      CMD_EOR: begin is_logic = 1'b1; result = op_a ^ op_b; end
      CMD_MOV: begin is_logic = 1'b1; result = op_b;        end
      CMD_MVN: begin is_logic = 1'b1; result = ~op_b;       end
      default: begin end
    endcase
    addend = is_sub ? ~op_b : op_b;
    sum    = {1'b0, op_a} + {1'b0, addend} + {{WIDTH{1'b0}}, carry_in};
    if (is_arith) begin
      result = sum[WIDTH-1:0];
    end
  end

  // Candidate flags: arithmetic sets all four, logic/move only N and Z,
  // undefined commands leave the status word untouched.
  always_comb begin
    flags_calc = sr_q;
    if (is_arith) begin
      flags_calc[3] = result[WIDTH-1];
      flags_calc[2] = (result == '0);
      flags_calc[1] = sum[WIDTH];
      // addend already carries ~b for subtraction, so one overflow rule covers both
      flags_calc[0] = (op_a[WIDTH-1] == addend[WIDTH-1]) &&
                      (result[WIDTH-1] != op_a[WIDTH-1]);
    end else if (is_logic) begin
      flags_calc[3] = result[WIDTH-1];
      flags_calc[2] = (result == '0);
    end
  end

  // Next-state selection: freeze > restore > update > hold; the shadow
  // captures the update path so a save in the same cycle sees the new flags.
  always_comb begin
    update   = ex_valid & s_bit & cond_pass & ~flush & ~freeze;
    sr_upd   = update ? flags_calc : sr_q;
    sr_d     = sr_q;
    shadow_d = shadow_q;
    if (!freeze) begin
      sr_d     = restore_sr ? shadow_q : sr_upd;
      shadow_d = save_sr ? sr_upd : shadow_q;
    end
  end

  // Status and shadow registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= 4'b0000;
      shadow_q <= 4'b0000;
    end else begin
      sr_q     <= sr_d;
      shadow_q <= shadow_d;
    end
  end

  assign alu_result = result;
  assign sr         = sr_q;
  assign sr_fwd     = sr_d;
  assign shadow_sr  = shadow_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// tb_status_flag_unit: directed table, reset corners and randomized run
// against an arithmetic reference model of the status flag unit.
module tb_status_flag_unit;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [3:0]  exe_cmd;
  logic        s_bit;
  logic        cond_pass;
  logic        freeze;
  logic        flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        save_sr;
  logic        restore_sr;
  logic [31:0] alu_result;
  logic [3:0]  sr;
  logic [3:0]  sr_fwd;
  logic [3:0]  shadow_sr;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] m_sr;
  logic [3:0] m_sh;

  status_flag_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .exe_cmd(exe_cmd),
    .s_bit(s_bit), .cond_pass(cond_pass), .freeze(freeze), .flush(flush),
    .op_a(op_a), .op_b(op_b), .save_sr(save_sr), .restore_sr(restore_sr),
    .alu_result(alu_result), .sr(sr), .sr_fwd(sr_fwd), .shadow_sr(shadow_sr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic        s, cp, fz, fl, sv, rs;
    logic [31:0] er;
    logic [3:0]  esr;
    logic [3:0]  esh;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] cmd, logic [31:0] a, logic [31:0] b,
                              logic s, logic cp, logic fz, logic fl, logic sv, logic rs,
                              logic [31:0] er, logic [3:0] esr, logic [3:0] esh);
    vec_t v;
    v.cmd = cmd; v.a = a; v.b = b; v.s = s; v.cp = cp; v.fz = fz; v.fl = fl;
    v.sv = sv; v.rs = rs; v.er = er; v.esr = esr; v.esh = esh;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic ev, logic [3:0] cmd, logic [31:0] a, logic [31:0] b,
                       logic s, logic cp, logic fz, logic fl, logic sv, logic rs);
    ex_valid = ev; exe_cmd = cmd; op_a = a; op_b = b; s_bit = s;
    cond_pass = cp; freeze = fz; flush = fl; save_sr = sv; restore_sr = rs;
  endtask

  // Reference model built from the instruction-set rules with 64-bit math.
  function automatic void model(logic ev, logic [3:0] cmd, logic [31:0] a, logic [31:0] b,
                                logic s, logic cp, logic fz, logic fl, logic sv, logic rs,
                                logic [3:0] cur, logic [3:0] sh,
                                output logic [31:0] r, output logic [3:0] nsr,
                                output logic [3:0] nsh);
    longint ua, ub, full, sa, sb, sres;
    logic [3:0] fl_new;
    logic [3:0] path;
    logic upd;
    longint cin;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    cin = cur[1] ? 1 : 0;
    fl_new = cur;
    r = 32'h0;
    case (cmd)
      4'd2, 4'd3: begin
        if (cmd == 4'd2) cin = 0;
        full = ua + ub + cin;
        sres = sa + sb + cin;
        r = full[31:0];
        fl_new = {r[31], r == 0, full >= 64'sd4294967296,
                  (sres > 64'sd2147483647) || (sres < -64'sd2147483648)};
      end
      4'd4, 4'd5: begin
        longint bor;
        bor = (cmd == 4'd4) ? 0 : 1 - cin;
        full = ua - ub - bor;
        sres = sa - sb - bor;
        r = full[31:0];
        fl_new = {r[31], r == 0, full >= 0,
                  (sres > 64'sd2147483647) || (sres < -64'sd2147483648)};
      end
      4'd6, 4'd7, 4'd8, 4'd1, 4'd9: begin
        case (cmd)
          4'd6: r = a & b;
          4'd7: r = a | b;
          4'd8: r = a ^ b;
          4'd1: r = b;
          default: r = ~b;
        endcase
        fl_new = {r[31], r == 0, cur[1:0]};
      end
      default: begin end
    endcase
    upd  = ev && s && cp && !fl && !fz;
    path = upd ? fl_new : cur;
    if (fz) begin
      nsr = cur; nsh = sh;
    end else begin
      nsr = rs ? sh : path;
      nsh = sv ? path : sh;
    end
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] specials [5];
    specials[0] = 32'h0; specials[1] = 32'h1; specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h8000_0000; specials[4] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 2) == 0) return specials[$urandom_range(0, 4)];
    return $urandom();
  endfunction

  initial begin
    logic [31:0] er;
    logic [3:0]  nsr, nsh;

    drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("reset_sr", {28'h0, sr}, 32'h0);
    chk("reset_shadow", {28'h0, shadow_sr}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("idle_sr", {28'h0, sr}, 32'h0);
    chk("idle_shadow", {28'h0, shadow_sr}, 32'h0);

    //         cmd    a             b             s  cp fz fl sv rs  result        sr       shadow
    tbl.push_back(mk(4'd4, 32'd5,        32'd5,        1, 1, 0, 0, 0, 0, 32'h0,        4'b0110, 4'b0000));
    tbl.push_back(mk(4'd2, 32'h7FFFFFFF, 32'd1,        1, 1, 0, 0, 0, 0, 32'h80000000, 4'b1001, 4'b0000));
    tbl.push_back(mk(4'd2, 32'hFFFFFFFF, 32'd1,        1, 1, 0, 0, 0, 0, 32'h0,        4'b0110, 4'b0000));
    tbl.push_back(mk(4'd3, 32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 32'h1,        4'b0000, 4'b0000));
    tbl.push_back(mk(4'd4, 32'd1,        32'd2,        1, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'd4, 32'd1,        32'd2,        1, 1, 0, 1, 0, 0, 32'hFFFFFFFF, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'd4, 32'd1,        32'd2,        1, 1, 1, 0, 0, 0, 32'hFFFFFFFF, 4'b0000, 4'b0000));
    tbl.push_back(mk(4'd4, 32'd1,        32'd2,        1, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 4'b1000, 4'b0000));
    tbl.push_back(mk(4'd4, 32'h80000000, 32'd1,        1, 1, 0, 0, 0, 0, 32'h7FFFFFFF, 4'b0011, 4'b0000));
    tbl.push_back(mk(4'd6, 32'hF0,       32'h0F,       1, 1, 0, 0, 0, 0, 32'h0,        4'b0111, 4'b0000));
    tbl.push_back(mk(4'd0, 32'd5,        32'd3,        1, 1, 0, 0, 0, 0, 32'h0,        4'b0111, 4'b0000));
    tbl.push_back(mk(4'd9, 32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 4'b1011, 4'b0000));
    tbl.push_back(mk(4'd4, 32'd5,        32'd5,        1, 1, 0, 0, 0, 0, 32'h0,        4'b0110, 4'b0000));
    tbl.push_back(mk(4'd0, 32'h0,        32'h0,        0, 1, 0, 0, 1, 0, 32'h0,        4'b0110, 4'b0110));
    tbl.push_back(mk(4'd4, 32'd1,        32'd2,        1, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 4'b1000, 4'b0110));
    tbl.push_back(mk(4'd2, 32'h7FFFFFFF, 32'd1,        1, 1, 0, 0, 0, 1, 32'h80000000, 4'b0110, 4'b0110));
    tbl.push_back(mk(4'd4, 32'd1,        32'd2,        1, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 4'b1000, 4'b0110));
    tbl.push_back(mk(4'd0, 32'h0,        32'h0,        0, 1, 0, 0, 1, 1, 32'h0,        4'b0110, 4'b1000));
    tbl.push_back(mk(4'd2, 32'h7FFFFFFF, 32'd1,        1, 1, 0, 0, 1, 0, 32'h80000000, 4'b1001, 4'b1001));
    tbl.push_back(mk(4'd4, 32'd1,        32'd2,        1, 1, 1, 0, 1, 1, 32'hFFFFFFFF, 4'b1001, 4'b1001));
    tbl.push_back(mk(4'd4, 32'd1,        32'd2,        1, 1, 0, 0, 1, 1, 32'hFFFFFFFF, 4'b1001, 4'b1000));
    tbl.push_back(mk(4'd5, 32'd0,        32'd0,        1, 1, 0, 0, 0, 0, 32'hFFFFFFFF, 4'b1000, 4'b1000));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(1'b1, tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].cp,
            tbl[i].fz, tbl[i].fl, tbl[i].sv, tbl[i].rs);
      @(negedge clk);
      chk($sformatf("row%0d_result", i), alu_result, tbl[i].er);
      chk($sformatf("row%0d_sr_fwd", i), {28'h0, sr_fwd}, {28'h0, tbl[i].esr});
      @(posedge clk); #1;
      chk($sformatf("row%0d_sr", i), {28'h0, sr}, {28'h0, tbl[i].esr});
      chk($sformatf("row%0d_shadow", i), {28'h0, shadow_sr}, {28'h0, tbl[i].esh});
      $display("[TB] row %0d cmd=%0d a=%h b=%h result=%h sr=%b shadow=%b",
               i, tbl[i].cmd, tbl[i].a, tbl[i].b, alu_result, sr, shadow_sr);
      m_sr = tbl[i].esr;
      m_sh = tbl[i].esh;
    end

    for (int n = 0; n < 400; n++) begin
      logic ev, s, cp, fz, fl, sv, rs;
      logic [3:0] cmd;
      logic [31:0] a, b;
      ev  = ($urandom_range(0, 7) != 0);
      cmd = 4'($urandom_range(0, 15));
      a   = rnd_op();
      b   = rnd_op();
      s   = ($urandom_range(0, 3) != 0);
      cp  = ($urandom_range(0, 5) != 0);
      fz  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 7) == 0);
      sv  = ($urandom_range(0, 7) == 0);
      rs  = ($urandom_range(0, 7) == 0);
      drive(ev, cmd, a, b, s, cp, fz, fl, sv, rs);
      model(ev, cmd, a, b, s, cp, fz, fl, sv, rs, m_sr, m_sh, er, nsr, nsh);
      @(negedge clk);
      chk($sformatf("rnd%0d_result", n), alu_result, er);
      chk($sformatf("rnd%0d_sr_fwd", n), {28'h0, sr_fwd}, {28'h0, nsr});
      @(posedge clk); #1;
      m_sr = nsr;
      m_sh = nsh;
      chk($sformatf("rnd%0d_sr", n), {28'h0, sr}, {28'h0, m_sr});
      chk($sformatf("rnd%0d_shadow", n), {28'h0, shadow_sr}, {28'h0, m_sh});
    end

    // Load known nonzero state, then clear it asynchronously mid-cycle.
    drive(1'b1, 4'd2, 32'h7FFFFFFF, 32'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("pre_reset_sr", {28'h0, sr}, 32'h9);
    chk("pre_reset_shadow", {28'h0, shadow_sr}, 32'h9);
    drive(1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_sr", {28'h0, sr}, 32'h0);
    chk("async_reset_shadow", {28'h0, shadow_sr}, 32'h0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_sr", {28'h0, sr}, 32'h0);
    chk("post_reset_shadow", {28'h0, shadow_sr}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Producer side of the NZCV status interface in the ARM pipeline.
- Sits in the execute stage: computes the ALU result and the next N/Z/C/V flags from the execute command, and holds the architectural status register.
- Drives the 4-bit status word consumed by condition evaluation.
- Also provides a one-entry shadow copy, saved and restored around exception entry and return.

Parameters:
- WIDTH, 32, operand/result width in bits (MSB used for N and V).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute-stage instruction valid this cycle
- exe_cmd  in  4  operation: 0001 MOV, 1001 MVN, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR; others = pass-through zero, no flag change
- s_bit  in  1  instruction requests flag update
- cond_pass  in  1  active-high: instruction's condition satisfied
- freeze  in  1  pipeline stall; holds all registers
- flush  in  1  squash current execute instruction
- op_a  in  WIDTH  first operand (Rn)
- op_b  in  WIDTH  second operand (shifter output)
- save_sr  in  1  pulse: copy sr into shadow
- restore_sr  in  1  pulse: load sr from shadow
- alu_result  out  WIDTH  combinational result
- sr  out  4  registered status {N,Z,C,V}, bit3 = N … bit0 = V
- sr_fwd  out  4  combinational value sr will take at the next edge (bypass)
- shadow_sr  out  4  registered shadow copy

Behaviour:
- Reset (rst_n low, async): sr = 4'b0000, shadow_sr = 4'b0000; held while low.
- Arithmetic is on WIDTH+1 bits; carry = bit WIDTH.
  - ADD: r = a+b, C = carry.
  - ADC: r = a+b+C_cur.
  - SUB: r = a-b, C = NOT borrow (1 when a >= b unsigned).
  - SBC: r = a-b-(~C_cur).
- V for ADD/ADC: a[MSB]==b[MSB] and r[MSB]!=a[MSB]. V for SUB/SBC: a[MSB]!=b[MSB] and r[MSB]!=a[MSB].
- Logical and move ops:
  - AND a&b, ORR a|b, EOR a^b, MOV b, MVN ~b.
  - N and Z are updated; C and V are kept from sr.
- Flags N = r[MSB], Z = (r == 0). Undefined exe_cmd: alu_result = 0, all flags kept.
- update = ex_valid & s_bit & cond_pass & ~flush & ~freeze.
- Next-state priority, highest first:
  1. freeze: hold sr and shadow_sr.
  2. restore_sr: sr <= shadow_sr (overrides update in the same cycle).
  3. update: sr <= computed flags.
  4. else hold.
- save_sr (when not frozen): shadow_sr <= sr_fwd, so a same-cycle update is captured.
- save_sr and restore_sr together: shadow_sr <= sr_fwd of the update path, then sr <= old shadow_sr (swap semantics).
- Latency:
  - sr changes exactly one edge after the qualifying cycle.
  - sr_fwd equals the next sr combinationally in the same cycle.
  - alu_result is valid in the same cycle regardless of s_bit, freeze or flush.
- ADC/SBC use the registered C, not sr_fwd, so back-to-back carries chain through one edge.
- flush or cond_pass = 0 with s_bit = 1: no flag change, sr_fwd = sr.
- Reset asserted mid-operation clears both registers immediately, with no edge needed.

Test Plan:
- Reset: drive rst_n = 0 between edges -> sr = 0000 and shadow_sr = 0000 immediately; after release with no update, they stay 0000.
- SUB, a = 5, b = 5, s_bit = 1, all qualifiers true -> alu_result = 0, sr_fwd = 0110 same cycle, sr = 0110 after the edge.
- ADD, a = 0x7FFFFFFF, b = 1 -> r = 0x80000000, sr = 1001. Then ADD, a = 0xFFFFFFFF, b = 1 -> r = 0, sr = 0110. Then ADC, a = 0, b = 0 -> r = 1, sr = 0000.
- Qualifier masking:
  - SUB, a = 1, b = 2 with cond_pass = 0 -> sr unchanged.
  - Same with flush = 1 -> unchanged.
  - Same with freeze = 1 -> unchanged.
  - With all qualifiers true -> sr = 1000 (r = 0xFFFFFFFF, borrow so C = 0).
- Logical op preserves C/V: set sr = 0011, then AND, a = 0xF0, b = 0x0F, s_bit = 1 -> r = 0, sr = 0111.
- Shadow:
  - sr = 0110; pulse save_sr -> shadow_sr = 0110.
  - Update to 1000, then pulse restore_sr with a concurrent update -> sr = 0110.
  - save_sr and restore_sr together swap sr and shadow_sr.
